// File: rtl/pwl_host_cmd_master.sv
// pwl_host_cmd_master: turns a valid/ready register-access request stream into
// the pwl_synth cycle-level command sequence (SET_ADDR, then WRITE or READ),
// captures read data and returns it on a valid/ready response channel.
module pwl_host_cmd_master #(
   parameter int TIMEOUT    = 64,
   parameter int ADDR_CACHE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [12:0] req_addr,
   input  logic [12:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [12:0] resp_data,
   output logic        resp_err,
   output logic [2:0]  cmd_out,
   output logic [12:0] wdata_out,
   input  logic [12:0] data_in,
   input  logic        data_ready_in
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   localparam logic [2:0] CMD_NOP      = 3'd0;
   localparam logic [2:0] CMD_SET_ADDR = 3'd1;
   localparam logic [2:0] CMD_WRITE    = 3'd2;
   localparam logic [2:0] CMD_READ     = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WAIT_RD,
      ST_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    cmd_q, cmd_d;
   logic [12:0]   wdata_q, wdata_d;
   logic          op_wr_q, op_wr_d;
   logic [12:0]   op_data_q, op_data_d;
   logic [12:0]   cache_addr_q, cache_addr_d;
   logic          cache_vld_q, cache_vld_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          resp_vld_q, resp_vld_d;
   logic [12:0]   resp_data_q, resp_data_d;
   logic          resp_err_q, resp_err_d;
   logic          hit;

   assign req_ready  = (state_q == ST_IDLE);
   assign cmd_out    = cmd_q;
   assign wdata_out  = wdata_q;
   assign resp_valid = resp_vld_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;

   // A hit lets the data command go out directly without a SET_ADDR cycle
   assign hit = (ADDR_CACHE != 0) && cache_vld_q && (cache_addr_q == req_addr);

   // Next-state, command issue, read capture and timeout decisions
   always_comb begin
      state_d      = state_q;
      cmd_d        = CMD_NOP;
      wdata_d      = wdata_q;
      op_wr_d      = op_wr_q;
      op_data_d    = op_data_q;
      cache_addr_d = cache_addr_q;
      cache_vld_d  = cache_vld_q;
      cnt_d        = cnt_q;
      resp_vld_d   = resp_vld_q;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (hit) begin
                  if (req_write) begin
                     cmd_d   = CMD_WRITE;
                     wdata_d = req_wdata;
                  end else begin
                     cmd_d   = CMD_READ;
                     cnt_d   = '0;
                     state_d = ST_WAIT_RD;
                  end
               end else begin
                  cmd_d        = CMD_SET_ADDR;
                  wdata_d      = req_addr;
                  op_wr_d      = req_write;
                  op_data_d    = req_wdata;
                  cache_addr_d = req_addr;
                  cache_vld_d  = 1'b1;
                  state_d      = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            if (op_wr_q) begin
               cmd_d   = CMD_WRITE;
               wdata_d = op_data_q;
               state_d = ST_IDLE;
            end else begin
               cmd_d   = CMD_READ;
               cnt_d   = '0;
               state_d = ST_WAIT_RD;
            end
         end
         ST_WAIT_RD: begin
            // Real data beats the timeout when both land in the same cycle
            if (data_ready_in) begin
               resp_data_d = data_in;
               resp_err_d  = 1'b0;
               resp_vld_d  = 1'b1;
               state_d     = ST_RESP;
            end else if (cnt_q == CNT_MAX) begin
               resp_data_d = '0;
               resp_err_d  = 1'b1;
               resp_vld_d  = 1'b1;
               cache_vld_d = 1'b0;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               resp_vld_d = 1'b0;
               cnt_d      = '0;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset abandons any in-flight sequence and clears the cache
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cmd_q        <= CMD_NOP;
         wdata_q      <= '0;
         op_wr_q      <= 1'b0;
         op_data_q    <= '0;
         cache_addr_q <= '0;
         cache_vld_q  <= 1'b0;
         cnt_q        <= '0;
         resp_vld_q   <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         wdata_q      <= wdata_d;
         op_wr_q      <= op_wr_d;
         op_data_q    <= op_data_d;
         cache_addr_q <= cache_addr_d;
         cache_vld_q  <= cache_vld_d;
         cnt_q        <= cnt_d;
         resp_vld_q   <= resp_vld_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
      end
   end

endmodule
